// File: rtl/imem_server_pkg.sv
// Shared constants, response record and instruction image for imem_server.
package imem_server_pkg;

    // Instruction word width and default memory geometry.
    localparam int unsigned INSTR_W             = 32;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h0000_3000;
    localparam int          DEFAULT_DEPTH_WORDS = 1024;

    // Name of the hex program image that rom_word() reproduces. The image is
    // expressed as a generator so the ROM is fixed at elaboration time.
    localparam CODE_FILE = "code.txt";

    // One response as it travels down the pipe and sits in the queue.
    typedef struct packed {
        logic [31:0]        addr;
        logic [INSTR_W-1:0] instr;
        logic               err;
    } rsp_entry_t;

    // Program image contents: word 0 is 32'h3c010000, later words are a
    // scrambled function of the word index so every location is distinct.
    function automatic logic [INSTR_W-1:0] rom_word(input logic [31:0] idx);
        return 32'h3c01_0000 ^ (idx * 32'h9e37_79b1);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response queue of {addr,instr,err} with push/pop/clear and
// full/empty flags. The head entry is presented combinationally.
module imem_rsp_fifo
    import imem_server_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  rsp_entry_t i_push_data,
    input  logic       i_pop,
    input  logic       i_clear,
    output rsp_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_fill;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_fill == CW'(DEPTH));
    assign o_empty   = (r_fill == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointer and fill bookkeeping; clear drops every entry in one edge.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_fill <= r_fill + CW'(1);
                2'b01:   r_fill <= r_fill - CW'(1);
                default: ;
            endcase
        end
    end

    // Entry storage write.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable once the fill count covers it, so its power-up value never
    // leaks out and the array can map onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/imem_server.sv
// Instruction memory server: accepts PC fetches, reads the ROM in the first
// pipeline stage, carries the result through LATENCY stages and returns
// responses in order through a QDEPTH-entry queue. Flush discards everything
// in flight except a request accepted in the same cycle.
module imem_server
    import imem_server_pkg::*;
#(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int          QDEPTH      = 4,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_addr,
    input  logic               flush,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic [31:0]        rsp_addr,
    output logic               rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [INSTR_W-1:0] w_rom [DEPTH_WORDS];
    logic [29:0]        w_index;
    logic               w_err;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    rsp_entry_t         w_new_entry;
    rsp_entry_t         w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    logic [CW-1:0]      r_outstanding;
    logic [LATENCY-1:0] r_stg_vld;
    rsp_entry_t         r_stg_data [LATENCY];

    // Read-only program storage, fixed at elaboration.
    for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_rom
        assign w_rom[g] = rom_word(32'(g));
    end

    // Word index uses wrap-around subtraction, so addresses below BASE_ADDR
    // land far above DEPTH_WORDS and are flagged as out of range.
    assign w_index = 30'((req_addr - BASE_ADDR) >> 2);
    assign w_err   = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, w_index} >= 32'(DEPTH_WORDS));

    // Handshakes. req_ready depends only on the registered count so it never
    // forms a combinational path from req_valid.
    assign req_ready = (r_outstanding < CW'(QDEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    // Build the stage-0 record: ROM read happens here, errors return zero.
    // NOTE: every field is assigned on every pass through this block, so no
    // latch is inferred.
    always_comb begin
        w_new_entry.addr  = req_addr;
        w_new_entry.err   = w_err;
        w_new_entry.instr = w_err ? '0 : w_rom[w_index[AW-1:0]];
    end

    // Stage valid bits: stage 0 takes the accept, later stages shift; flush
    // kills everything already in flight but keeps a same-cycle accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stg_vld <= '0;
        end else begin
            r_stg_vld[0] <= w_accept;
            for (int s = 1; s < LATENCY; s++) begin
                r_stg_vld[s] <= flush ? 1'b0 : r_stg_vld[s-1];
            end
        end
    end

    // Stage data: captured on accept, then carried unchanged.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stg_data[0] <= w_new_entry;
        end
        for (int s = 1; s < LATENCY; s++) begin
            r_stg_data[s] <= r_stg_data[s-1];
        end
    end

    // Outstanding requests: in-pipe plus queued. Flush leaves only a
    // request accepted in the flush cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else if (flush) begin
            r_outstanding <= w_accept ? CW'(1) : '0;
        end else if (w_accept && !w_pop) begin
            r_outstanding <= r_outstanding + CW'(1);
        end else if (!w_accept && w_pop) begin
            r_outstanding <= r_outstanding - CW'(1);
        end
    end

    // The outstanding limit already reserves a slot for every in-pipe
    // request; the full check only keeps the queue safe if that is broken.
    assign w_push = r_stg_vld[LATENCY-1] && !w_fifo_full;

    imem_rsp_fifo #(
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (r_stg_data[LATENCY-1]),
        .i_pop       (w_pop),
        .i_clear     (flush),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Response fields read as zero whenever nothing is presented, which
    // covers the whole time reset is held.
    assign rsp_valid = !w_fifo_empty;
    assign rsp_instr = w_fifo_empty ? '0 : w_head.instr;
    assign rsp_addr  = w_fifo_empty ? '0 : w_head.addr;
    assign rsp_err   = w_fifo_empty ? 1'b0 : w_head.err;

endmodule

// File: tb/tb_imem_server.sv
// Self-checking bench for imem_server: directed scenarios plus a random
// phase, all compared every cycle against a transaction-level model that
// tracks pending responses and the cycle each one becomes visible.
module tb_imem_server;

    localparam int          LATENCY     = 2;
    localparam int          DEPTH_WORDS = 1024;
    localparam int          QDEPTH      = 4;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;

    imem_server #(
        .LATENCY     (LATENCY),
        .DEPTH_WORDS (DEPTH_WORDS),
        .QDEPTH      (QDEPTH),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Expected response plus the bench cycle from which it may be seen.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          due;
    } exp_t;

    exp_t mq[$];
    int   cyc;
    int   total;
    int   bad;

    // Contents of the program image (word 0 = 32'h3c010000).
    function automatic logic [31:0] image_word(input logic [31:0] idx);
        return 32'h3c01_0000 ^ (idx * 32'h9e37_79b1);
    endfunction

    // What a fetch of address a should return.
    function automatic exp_t model(input logic [31:0] a);
        exp_t        e;
        logic [31:0] off;
        off     = a - BASE_ADDR;
        e.addr  = a;
        e.err   = (a[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH_WORDS));
        e.instr = e.err ? 32'h0 : image_word(off >> 2);
        e.due   = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic head_visible();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    task automatic check_outputs();
        logic vis;
        vis = head_visible();
        check("req_ready", 32'(req_ready), 32'(mq.size() < QDEPTH));
        check("rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis) begin
            check("rsp_addr", rsp_addr, mq[0].addr);
            check("rsp_instr", rsp_instr, mq[0].instr);
            check("rsp_err", 32'(rsp_err), 32'(mq[0].err));
        end
    endtask

    // One clock: drive inputs, compare outputs, advance, update the model.
    // Called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [31:0] a, input logic f, input logic rr);
        logic acc;
        logic pop;
        exp_t e;
        req_valid = v;
        req_addr  = a;
        flush     = f;
        rsp_ready = rr;
        check_outputs();
        acc = v && (mq.size() < QDEPTH);
        pop = rr && head_visible();
        @(posedge clk);
        cyc++;
        #1;
        if (pop) void'(mq.pop_front());
        if (f) mq.delete();
        if (acc) begin
            e     = model(a);
            e.due = cyc + LATENCY;
            mq.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, rr);
    endtask

    initial begin
        logic        v;
        logic        f;
        logic        rr;
        logic [31:0] a;
        int          sel;
        int          thru;

        clk       = 1'b0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        total     = 0;
        bad       = 0;
        cyc       = 0;

        // Outputs while reset is held.
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_rsp_addr", rsp_addr, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single fetch of word 0: visible LATENCY cycles after the accept edge.
        step(1'b1, 32'h0000_3000, 1'b0, 1'b1);
        check("lat_early", 32'(rsp_valid), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("lat_valid", 32'(rsp_valid), 32'd1);
        check("lat_instr", rsp_instr, 32'h3c01_0000);
        check("lat_err", 32'(rsp_err), 32'd0);
        idle(2, 1'b1);

        // Back-to-back fetches with the consumer stalled: the fifth waits.
        step(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3004, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3008, 1'b0, 1'b0);
        step(1'b1, 32'h0000_300c, 1'b0, 1'b0);
        check("full_ready", 32'(req_ready), 32'd0);
        step(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        check("stall_addr", rsp_addr, 32'h0000_3000);
        step(1'b1, 32'h0000_3010, 1'b0, 1'b1);
        check("after_pop_ready", 32'(req_ready), 32'd1);
        step(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        idle(8, 1'b1);

        // Error boundaries: misaligned, below base, last valid word.
        step(1'b1, 32'h0000_3002, 1'b0, 1'b1);
        step(1'b1, 32'h0000_2ffc, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3ffc, 1'b0, 1'b1);
        check("misal_err", 32'(rsp_err), 32'd1);
        check("misal_instr", rsp_instr, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("below_err", 32'(rsp_err), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("last_err", 32'(rsp_err), 32'd0);
        check("last_instr", rsp_instr, image_word(32'd1023));
        idle(3, 1'b1);

        // Flush with three outstanding and a simultaneous new request.
        step(1'b1, 32'h0000_3010, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3014, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3018, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3040, 1'b1, 1'b0);
        check("flush_valid0", 32'(rsp_valid), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_valid1", 32'(rsp_valid), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_kept_valid", 32'(rsp_valid), 32'd1);
        check("flush_kept_addr", rsp_addr, 32'h0000_3040);
        step(1'b1, 32'h0000_3044, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3048, 1'b0, 1'b0);
        step(1'b1, 32'h0000_304c, 1'b0, 1'b0);
        check("flush_count_full", 32'(req_ready), 32'd0);
        idle(8, 1'b1);

        // Steady state at QDEPTH-1 outstanding: one accept and one return per cycle.
        step(1'b1, 32'h0000_3100, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3104, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3108, 1'b0, 1'b0);
        idle(2, 1'b0);
        thru = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready && rsp_valid) thru++;
            step(1'b1, 32'h0000_3200 + 32'(i * 4), 1'b0, 1'b1);
        end
        check("steady_throughput", 32'(thru), 32'd20);
        idle(8, 1'b1);

        // Asynchronous reset mid-cycle with two responses queued.
        step(1'b1, 32'h0000_3000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3004, 1'b0, 1'b0);
        idle(2, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_addr", rsp_addr, 32'h0);
        mq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(3, 1'b1);
        step(1'b1, 32'h0000_3008, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 19) == 0);
            rr  = ($urandom_range(0, 2) != 0);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0, 1, 2: a = BASE_ADDR + (32'($urandom_range(0, 1023)) << 2);
                3:       a = BASE_ADDR + (32'($urandom_range(0, 1023)) << 2)
                             + 32'($urandom_range(1, 3));
                4:       a = BASE_ADDR - (32'($urandom_range(1, 8)) << 2);
                5:       a = ($urandom_range(0, 1) != 0) ? 32'h0000_3ffc : 32'h0000_4000;
                default: a = $urandom();
            endcase
            step(v, a, f, rr);
        end
        idle(10, 1'b1);
        check("final_rsp_valid", 32'(rsp_valid), 32'd0);
        check("final_req_ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
